// File: rtl/j17_arb_pkg.sv
// Shared types and default widths for the j17 RAM arbiter.
// Optional build macro J17_ARB_ROUND_ROBIN_EN selects alternating arbitration.
package j17_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_e;

endpackage

// File: rtl/j17_arb_pick.sv
// Combinational winner select for the j17 RAM arbiter.
// J17_ARB_ROUND_ROBIN_EN: alternate on contention; otherwise DM priority with IF starvation guard.
module j17_arb_pick
  import j17_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic             if_req,
  input  logic             dm_req,
`ifdef J17_ARB_ROUND_ROBIN_EN
  input  req_id_e          last_win,
`else
  input  logic [CNT_W-1:0] starve_cnt,
`endif
  output logic             any_req_c,
  output req_id_e          win_c
);

  always_comb begin
    any_req_c = if_req | dm_req;
    win_c     = REQ_IF;
`ifdef J17_ARB_ROUND_ROBIN_EN
    // DM takes it alone, or on contention when IF had the previous grant
    if (dm_req && (!if_req || (last_win == REQ_IF))) win_c = REQ_DM;
`else
    // IF is force-granted once it has lost STARVE_MAX times in a row
    if (dm_req && !(if_req && (starve_cnt == CNT_W'(STARVE_MAX)))) win_c = REQ_DM;
`endif
  end

endmodule

// File: rtl/j17_ram_arbiter.sv
// Single-port RAM arbiter between instruction fetch (IF) and load/store (DM): one access at a time.
// Build macro J17_ARB_ROUND_ROBIN_EN replaces the starvation counter with round-robin selection.
module j17_ram_arbiter
  import j17_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_value,
  input  logic [DATA_W-1:0] ram_result
);

  state_e            state_q, state_d;
  req_id_e           owner_q, owner_d;
  logic              is_read_q, is_read_d;
  logic              gnt_q, gnt_d;
  logic              rvalid_q, rvalid_d;
  logic              ram_write_q, ram_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              any_req;
  req_id_e           win;

`ifdef J17_ARB_ROUND_ROBIN_EN
  j17_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .if_req    (if_req),
    .dm_req    (dm_req),
    .last_win  (owner_q),
    .any_req_c (any_req),
    .win_c     (win)
  );
`else
  logic [CNT_W-1:0] cnt_q, cnt_d;

  j17_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .starve_cnt (cnt_q),
    .any_req_c  (any_req),
    .win_c      (win)
  );
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    is_read_d   = is_read_q;
    gnt_d       = 1'b0;
    rvalid_d    = 1'b0;
    ram_write_d = 1'b0;
    addr_d      = addr_q;
    value_d     = value_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
`ifndef J17_ARB_ROUND_ROBIN_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifndef J17_ARB_ROUND_ROBIN_EN
        if (!if_req || (win == REQ_IF)) cnt_d = '0;
        else if (cnt_q != CNT_W'(STARVE_MAX)) cnt_d = cnt_q + CNT_W'(1);
`endif
        if (any_req) begin
          state_d = ST_ACCESS;
          owner_d = win;
          gnt_d   = 1'b1;
          if (win == REQ_DM) begin
            addr_d      = dm_addr;
            value_d     = dm_wdata;
            ram_write_d = dm_we;
            is_read_d   = !dm_we;
          end else begin
            addr_d    = if_addr;
            is_read_d = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        state_d  = is_read_q ? ST_RESP : ST_IDLE;
        rvalid_d = is_read_q;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (owner_q == REQ_IF) if_rdata_d = ram_result;
        else                   dm_rdata_d = ram_result;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= REQ_IF;
      is_read_q   <= 1'b0;
      gnt_q       <= 1'b0;
      rvalid_q    <= 1'b0;
      ram_write_q <= 1'b0;
      addr_q      <= '0;
      value_q     <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
`ifndef J17_ARB_ROUND_ROBIN_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      is_read_q   <= is_read_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      ram_write_q <= ram_write_d;
      addr_q      <= addr_d;
      value_q     <= value_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
`ifndef J17_ARB_ROUND_ROBIN_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Reset in the same cycle suppresses pulses and the RAM write
  assign if_gnt    = gnt_q    && (owner_q == REQ_IF) && !reset;
  assign dm_gnt    = gnt_q    && (owner_q == REQ_DM) && !reset;
  assign if_rvalid = rvalid_q && (owner_q == REQ_IF) && !reset;
  assign dm_rvalid = rvalid_q && (owner_q == REQ_DM) && !reset;
  assign ram_write = ram_write_q && !reset;
  assign ram_addr  = addr_q;
  assign ram_value = value_q;

  // RAM data passes straight through while valid, then is held
  assign if_rdata = if_rvalid ? ram_result : if_rdata_q;
  assign dm_rdata = dm_rvalid ? ram_result : dm_rdata_q;

endmodule
